// File: rtl/dac_scheduler.sv
// Shares one serial DAC among NUM_CH requesters: round-robin grant, {ch,01,data} word build,
// MSB-first serialisation on nSync/dac_sclk/dac_din and nLdac update pulsing.
module dac_scheduler #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned SCLK_DIV   = 2,
    parameter int unsigned SYNC_GAP   = 2,
    parameter int unsigned LDAC_WIDTH = 2
) (
    input  logic                 ebi_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 ldac_mode,
    input  logic [NUM_CH-1:0]    req,
    input  logic [12*NUM_CH-1:0] req_data,
    output logic [NUM_CH-1:0]    ack,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic                 dac_sclk,
    output logic                 nSync,
    output logic                 nLdac,
    output logic                 dac_din
);
    localparam int unsigned CNT_A   = (SCLK_DIV > SYNC_GAP) ? SCLK_DIV : SYNC_GAP;
    localparam int unsigned CNT_MAX = (CNT_A > LDAC_WIDTH) ? CNT_A : LDAC_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned HALF_W  = 5;

    typedef enum logic [2:0] {IDLE, ARB, SHIFT, GAP, LDAC} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, ptr_nx, win, win_nx, win_c, hi_idx, lo_idx;
    logic               hi_found, any_req, start_c;
    logic [14:0]        shreg, shreg_nx;
    logic [HALF_W-1:0]  half, half_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [15:0]        frame_cnt_nx;
    logic [NUM_CH-1:0]  ack_nx;
    logic               busy_nx, sclk_nx, nsync_nx, nldac_nx, din_nx;
    logic [DATA_W-1:0]  word_data;
    logic [15:0]        word;

    assign any_req = |req;

    // Round-robin pick: lowest request above the pointer, else lowest overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (i > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        win_c = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        word_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win == IDX_W'(i)) word_data = req_data[DATA_W*i +: DATA_W];
        end
        word = {win, 2'b01, word_data};
    end

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        win_nx       = win;
        shreg_nx     = shreg;
        half_nx      = half;
        cnt_nx       = cnt;
        frame_cnt_nx = frame_cnt;
        busy_nx      = busy;
        sclk_nx      = dac_sclk;
        nsync_nx     = nSync;
        nldac_nx     = nLdac;
        din_nx       = dac_din;
        start_c      = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && any_req) start_c = 1'b1;
            end
            ARB: begin
                state_nx = SHIFT;
                shreg_nx = word[14:0];
                half_nx  = '0;
                cnt_nx   = '0;
                sclk_nx  = 1'b1;
                nsync_nx = 1'b0;
                din_nx   = word[15];
            end
            SHIFT: begin
                // Each half period is SCLK_DIV cycles; odd->even half boundaries are rising edges.
                if (cnt == CNT_W'(SCLK_DIV - 1)) begin
                    cnt_nx = '0;
                    if (half == HALF_W'(31)) begin
                        state_nx     = GAP;
                        sclk_nx      = 1'b1;
                        nsync_nx     = 1'b1;
                        din_nx       = 1'b0;
                        frame_cnt_nx = frame_cnt + 16'd1;
                    end else begin
                        half_nx = half + HALF_W'(1);
                        sclk_nx = ~dac_sclk;
                        if (half[0]) begin
                            shreg_nx = {shreg[13:0], 1'b0};
                            din_nx   = shreg[14];
                        end
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(SYNC_GAP - 1)) begin
                    cnt_nx = '0;
                    if (ldac_mode && enable && any_req) begin
                        start_c = 1'b1;
                    end else begin
                        state_nx = LDAC;
                        nldac_nx = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            LDAC: begin
                if (cnt == CNT_W'(LDAC_WIDTH - 1)) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    nldac_nx = 1'b1;
                    busy_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        // Grant is decided on entry to ARB so ack can be a flop asserted during ARB.
        if (start_c) begin
            state_nx = ARB;
            busy_nx  = 1'b1;
            win_nx   = win_c;
            ptr_nx   = win_c;
        end
    end

    always_comb begin
        ack_nx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ack_nx[i] = start_c && (win_c == IDX_W'(i));
        end
    end

    always_ff @(posedge ebi_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= IDX_W'(NUM_CH - 1);
            win       <= '0;
            shreg     <= '0;
            half      <= '0;
            cnt       <= '0;
            frame_cnt <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            dac_sclk  <= 1'b1;
            nSync     <= 1'b1;
            nLdac     <= 1'b1;
            dac_din   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            win       <= win_nx;
            shreg     <= shreg_nx;
            half      <= half_nx;
            cnt       <= cnt_nx;
            frame_cnt <= frame_cnt_nx;
            ack       <= ack_nx;
            busy      <= busy_nx;
            dac_sclk  <= sclk_nx;
            nSync     <= nsync_nx;
            nLdac     <= nldac_nx;
            dac_din   <= din_nx;
        end
    end
endmodule

// File: tb/tb_dac_scheduler.sv
// Scoreboard bench for dac_scheduler: expected DAC words queued at stimulus time,
// compared against words rebuilt from the serial pins by a monitor.
module tb_dac_scheduler;
    localparam int unsigned NUM_CH = 4;

    logic                 ebi_clk   = 1'b0;
    logic                 reset     = 1'b1;
    logic                 enable    = 1'b1;
    logic                 ldac_mode = 1'b0;
    logic [NUM_CH-1:0]    req       = '0;
    logic [12*NUM_CH-1:0] req_data  = '0;
    logic [NUM_CH-1:0]    ack;
    logic                 busy;
    logic [15:0]          frame_cnt;
    logic                 dac_sclk, nSync, nLdac, dac_din;

    int errors = 0;
    int checks = 0;
    int exp_frames = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          ack_q[$];

    int          cyc = 0;
    logic        prev_sclk = 1'b1, prev_nsync = 1'b1, prev_nldac = 1'b1, prev_busy = 1'b0;
    logic [15:0] sh = '0;
    int          nbits = 0, nsync_len = 0, ldac_len = 0;
    int          last_sync_len = 0, last_ldac_w = 0;
    int          ldac_pulses = 0, sync_falls = 0, busy_falls = 0;
    int          frame_end_cyc = 0, ldac_fall_cyc = 0;

    dac_scheduler #(.NUM_CH(NUM_CH), .SCLK_DIV(2), .SYNC_GAP(2), .LDAC_WIDTH(2)) dut (
        .ebi_clk(ebi_clk), .reset(reset), .enable(enable), .ldac_mode(ldac_mode),
        .req(req), .req_data(req_data), .ack(ack), .busy(busy), .frame_cnt(frame_cnt),
        .dac_sclk(dac_sclk), .nSync(nSync), .nLdac(nLdac), .dac_din(dac_din)
    );

    always #5 ebi_clk = ~ebi_clk;

    // Pin monitor: rebuilds words from falling sclk edges inside nSync-low windows.
    always @(negedge ebi_clk) begin
        cyc++;
        if (reset) begin
            nbits = 0; sh = '0; nsync_len = 0; ldac_len = 0;
            prev_sclk = 1'b1; prev_nsync = 1'b1; prev_nldac = 1'b1; prev_busy = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) if (ack[i]) ack_q.push_back(i);
            if (!nSync) begin
                if (prev_nsync) begin
                    sync_falls++; nbits = 0; sh = '0; nsync_len = 0;
                end
                nsync_len++;
                if (prev_sclk && !dac_sclk) begin
                    sh = {sh[14:0], dac_din};
                    nbits++;
                end
            end else if (!prev_nsync) begin
                got_q.push_back(sh);
                last_sync_len = nsync_len;
                frame_end_cyc = cyc;
                nbits = 0;
            end
            if (!nLdac) begin
                if (prev_nldac) begin
                    ldac_len = 0; ldac_fall_cyc = cyc;
                end
                ldac_len++;
            end else if (!prev_nldac) begin
                last_ldac_w = ldac_len;
                ldac_pulses++;
            end
            if (prev_busy && !busy) busy_falls++;
            prev_sclk = dac_sclk; prev_nsync = nSync; prev_nldac = nLdac; prev_busy = busy;
        end
    end

    task automatic tick();
        @(negedge ebi_clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [11:0] val);
        req_data[12*ch +: 12] = val;
    endtask

    function automatic logic [15:0] mk_word(input int ch);
        logic [11:0] d;
        d = req_data[12*ch +: 12];
        return {2'(ch), 2'b01, d};
    endfunction

    // Runs until every request has been acked (and dropped) and the block is idle.
    task automatic serve(input int budget);
        int n = 0;
        do begin
            tick();
            for (int i = 0; i < NUM_CH; i++) if (ack[i]) req[i] = 1'b0;
            n++;
        end while ((req != '0 || busy) && n < budget);
        checks++;
        if (n >= budget) begin
            errors++; $display("FAIL serve_timeout cycles=%0d limit=%0d", n, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({nSync, nLdac, dac_sclk, dac_din, busy, ack} !== 9'b1_1_1_0_0_0000) begin
            errors++; $display("FAIL reset_pins got=%b exp=%b", {nSync, nLdac, dac_sclk, dac_din, busy, ack}, 9'b111000000);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt);
        end
        reset = 1'b0;
        repeat (4) tick();
        checks++;
        if ({nSync, nLdac, dac_sclk, dac_din, busy} !== 5'b11100) begin
            errors++; $display("FAIL idle_pins got=%b exp=11100", {nSync, nLdac, dac_sclk, dac_din, busy});
        end
    endtask

    task automatic test_single();
        logic [15:0] ew, gw;
        int ga;
        int l0 = ldac_pulses;
        set_data(0, 12'hA5C);
        exp_q.push_back(16'h1A5C);
        req = 4'b0001;
        serve(1000);
        exp_frames++;
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            if (got_q.size() > 0) gw = got_q.pop_front(); else gw = 'x;
            if (ack_q.size() > 0) ga = ack_q.pop_front(); else ga = -1;
            checks++;
            if (gw !== ew) begin errors++; $display("FAIL single_word got=%h exp=%h", gw, ew); end
            checks++;
            if (ga != int'(ew[15:14])) begin errors++; $display("FAIL single_ack got=%0d exp=%0d", ga, ew[15:14]); end
        end
        checks++;
        if (ack_q.size() != 0) begin errors++; $display("FAIL single_extra_ack got=%0d exp=0", ack_q.size()); end
        checks++;
        if (last_sync_len != 64) begin errors++; $display("FAIL single_nsync_len got=%0d exp=64", last_sync_len); end
        checks++;
        if (ldac_pulses - l0 != 1) begin errors++; $display("FAIL single_ldac_count got=%0d exp=1", ldac_pulses - l0); end
        checks++;
        if (last_ldac_w != 2) begin errors++; $display("FAIL single_ldac_width got=%0d exp=2", last_ldac_w); end
        checks++;
        if (ldac_fall_cyc - frame_end_cyc != 2) begin
            errors++; $display("FAIL single_sync_gap got=%0d exp=2", ldac_fall_cyc - frame_end_cyc);
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL single_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_round_robin();
        logic [15:0] ew, gw;
        int ga;
        int l0;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        exp_frames = 0;
        l0 = ldac_pulses;
        for (int i = 0; i < NUM_CH; i++) begin
            set_data(i, 12'(12'h111 * (i + 1)));
            exp_q.push_back(mk_word(i));
        end
        req = 4'b1111;
        serve(2000);
        exp_frames += 4;
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            if (got_q.size() > 0) gw = got_q.pop_front(); else gw = 'x;
            if (ack_q.size() > 0) ga = ack_q.pop_front(); else ga = -1;
            checks++;
            if (gw !== ew) begin errors++; $display("FAIL rr_word got=%h exp=%h", gw, ew); end
            checks++;
            if (ga != int'(ew[15:14])) begin errors++; $display("FAIL rr_ack_order got=%0d exp=%0d", ga, ew[15:14]); end
        end
        checks++;
        if (ldac_pulses - l0 != 4) begin errors++; $display("FAIL rr_ldac_count got=%0d exp=4", ldac_pulses - l0); end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL rr_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_fairness();
        logic [15:0] ew, gw;
        int ga;
        int nacks = 0, n = 0;
        int l0 = ldac_pulses;
        set_data(0, 12'h0F0);
        set_data(2, 12'hC3C);
        for (int k = 0; k < 4; k++) exp_q.push_back(mk_word((k % 2 == 0) ? 0 : 2));
        req = 4'b0101;
        while (nacks < 4 && n < 2000) begin
            tick(); n++;
            if (ack != '0) nacks++;
        end
        req = '0;
        checks++;
        if (nacks != 4) begin errors++; $display("FAIL fair_grants got=%0d exp=4", nacks); end
        n = 0;
        while (busy && n < 1000) begin tick(); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL fair_idle_timeout busy=%b exp=0", busy); end
        exp_frames += 4;
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            if (got_q.size() > 0) gw = got_q.pop_front(); else gw = 'x;
            if (ack_q.size() > 0) ga = ack_q.pop_front(); else ga = -1;
            checks++;
            if (gw !== ew) begin errors++; $display("FAIL fair_word got=%h exp=%h", gw, ew); end
            checks++;
            if (ga != int'(ew[15:14])) begin errors++; $display("FAIL fair_grant_order got=%0d exp=%0d", ga, ew[15:14]); end
        end
        checks++;
        if (ldac_pulses - l0 != 4) begin errors++; $display("FAIL fair_ldac_count got=%0d exp=4", ldac_pulses - l0); end
    endtask

    task automatic test_batched();
        logic [15:0] ew, gw;
        int ga;
        int l0 = ldac_pulses;
        int b0 = busy_falls;
        ldac_mode = 1'b1;
        set_data(0, 12'h001);
        set_data(1, 12'h802);
        set_data(2, 12'h404);
        for (int i = 0; i < 3; i++) exp_q.push_back(mk_word(i));
        req = 4'b0111;
        serve(2000);
        ldac_mode = 1'b0;
        exp_frames += 3;
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            if (got_q.size() > 0) gw = got_q.pop_front(); else gw = 'x;
            if (ack_q.size() > 0) ga = ack_q.pop_front(); else ga = -1;
            checks++;
            if (gw !== ew) begin errors++; $display("FAIL batch_word got=%h exp=%h", gw, ew); end
            checks++;
            if (ga != int'(ew[15:14])) begin errors++; $display("FAIL batch_ack got=%0d exp=%0d", ga, ew[15:14]); end
        end
        checks++;
        if (ldac_pulses - l0 != 1) begin errors++; $display("FAIL batch_ldac_count got=%0d exp=1", ldac_pulses - l0); end
        checks++;
        if (busy_falls - b0 != 1) begin errors++; $display("FAIL batch_back_to_back busy_falls=%0d exp=1", busy_falls - b0); end
        checks++;
        if (ldac_fall_cyc - frame_end_cyc != 2) begin
            errors++; $display("FAIL batch_ldac_after_last got=%0d exp=2", ldac_fall_cyc - frame_end_cyc);
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL batch_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] ew, gw;
        int ga;
        int n = 0;
        set_data(1, 12'h7E1);
        req = 4'b0010;
        while (nbits < 5 && n < 500) begin tick(); n++; end
        checks++;
        if (nbits != 5) begin errors++; $display("FAIL midrst_edges got=%0d exp=5", nbits); end
        reset = 1'b1;
        req = '0;
        #1;
        checks++;
        if ({nSync, dac_sclk, nLdac, busy, ack} !== 8'b1_1_1_0_0000) begin
            errors++; $display("FAIL midrst_pins got=%b exp=11100000", {nSync, dac_sclk, nLdac, busy, ack});
        end
        if (ack_q.size() > 0) ga = ack_q.pop_front(); else ga = -1;
        checks++;
        if (ga != 1) begin errors++; $display("FAIL midrst_first_ack got=%0d exp=1", ga); end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        exp_frames = 0;
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL midrst_partial_frame got=%0d exp=0", got_q.size()); end
        set_data(0, 12'h5A5);
        set_data(3, 12'hFFF);
        exp_q.push_back(mk_word(0));
        exp_q.push_back(mk_word(1));
        exp_q.push_back(mk_word(3));
        req = 4'b1011;
        serve(2000);
        exp_frames += 3;
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            if (got_q.size() > 0) gw = got_q.pop_front(); else gw = 'x;
            if (ack_q.size() > 0) ga = ack_q.pop_front(); else ga = -1;
            checks++;
            if (gw !== ew) begin errors++; $display("FAIL midrst_word got=%h exp=%h", gw, ew); end
            checks++;
            if (ga != int'(ew[15:14])) begin errors++; $display("FAIL midrst_ack got=%0d exp=%0d", ga, ew[15:14]); end
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL midrst_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_enable_wrap();
        logic [15:0] ew, gw;
        int ga;
        int s0;
        @(negedge ebi_clk);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge ebi_clk);
        #1;
        release dut.frame_cnt;
        tick();
        checks++;
        if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got=%0d exp=65535", frame_cnt); end
        set_data(2, 12'h123);
        exp_q.push_back(mk_word(2));
        req = 4'b0100;
        serve(1000);
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL wrap_frame_cnt got=%0d exp=0", frame_cnt); end
        enable = 1'b0;
        s0 = sync_falls;
        set_data(0, 12'h9AB);
        req = 4'b0001;
        repeat (40) tick();
        checks++;
        if (ack_q.size() != 1) begin errors++; $display("FAIL enable_low_ack queued=%0d exp=1", ack_q.size()); end
        checks++;
        if (sync_falls != s0 || nSync !== 1'b1) begin
            errors++; $display("FAIL enable_low_nsync falls=%0d exp=0", sync_falls - s0);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL enable_low_busy got=%b exp=0", busy); end
        exp_q.push_back(mk_word(0));
        enable = 1'b1;
        serve(1000);
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            if (got_q.size() > 0) gw = got_q.pop_front(); else gw = 'x;
            if (ack_q.size() > 0) ga = ack_q.pop_front(); else ga = -1;
            checks++;
            if (gw !== ew) begin errors++; $display("FAIL enable_word got=%h exp=%h", gw, ew); end
            checks++;
            if (ga != int'(ew[15:14])) begin errors++; $display("FAIL enable_ack got=%0d exp=%0d", ga, ew[15:14]); end
        end
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL enable_frame_cnt got=%0d exp=1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_batched();
        test_reset_mid_frame();
        test_enable_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
